// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and NZCV flag layout for the MiniMicro register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF = 16;
  localparam int PC_IDX_DEF = NREGS_DEF - 1;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; a new producer (set) beats a retiring one (clear)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREGS-1:0]  clr,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  output logic [NREGS-1:0]  busy_vec,
  output logic [NREGS-1:0]  busy_next
);
  logic [NREGS-1:0] set_mask;
  always_comb begin
    set_mask = set ? NREGS'(1) << set_addr : '0;
    busy_next = (busy_vec & ~clr) | set_mask;
    busy_next[NREGS-1] = 1'b0;
  end
  always_ff @(posedge clk) busy_vec <= rst ? '0 : busy_next;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-through reads, virtual PC, NZCV flags and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 3,
  parameter int NWR = 2,
  parameter int PC_OFFSET = 8,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]     pc_in,
  output logic                  pc_wr_valid,
  output logic [DATA_W-1:0]     pc_wr_data,
  input  logic                  busy_set,
  input  logic [ADDR_W-1:0]     busy_addr,
  output logic [NREGS-1:0]      busy_vec,
  input  logic                  flags_we,
  input  logic [3:0]            flags_in,
  output logic [3:0]            flags
);
  localparam int PC_IDX = NREGS - 1;
  logic [DATA_W-1:0] regs [NREGS-1];
  logic [ADDR_W-1:0] wa [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic [ADDR_W-1:0] ra [NRD];
  logic [DATA_W-1:0] nval [NREGS];
  logic [NREGS-1:0]  wmask;
  logic [NREGS-1:0]  busy_next;
  flags_t            flags_q;
  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
    assign wd[j] = wr_data[j*DATA_W +: DATA_W];
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end
  // nval is the post-write view of every register; later ports override earlier ones
  always_comb begin
    wmask = '0;
    for (int r = 0; r < NREGS - 1; r++) nval[r] = regs[r];
    nval[PC_IDX] = '0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j]) begin
        wmask[wa[j]] = 1'b1;
        nval[wa[j]] = wd[j];
      end
  end
  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk),
    .rst(rst),
    .clr(wmask),
    .set(busy_set),
    .set_addr(busy_addr),
    .busy_vec(busy_vec),
    .busy_next(busy_next)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS - 1; r++) regs[r] <= '0;
      rd_data <= '0;
      rd_busy <= '0;
      pc_wr_valid <= 1'b0;
      pc_wr_data <= '0;
      flags_q <= '0;
    end else begin
      for (int r = 0; r < NREGS - 1; r++) regs[r] <= nval[r];
      for (int i = 0; i < NRD; i++) begin
        rd_data[i*DATA_W +: DATA_W] <= (ra[i] == ADDR_W'(PC_IDX)) ? pc_in + DATA_W'(PC_OFFSET) : nval[ra[i]];
        rd_busy[i] <= busy_next[ra[i]];
      end
      pc_wr_valid <= wmask[PC_IDX];
      pc_wr_data <= nval[PC_IDX];
      if (flags_we) flags_q <= flags_t'(flags_in);
    end
  end
  assign flags = flags_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors with a queued scoreboard checked by an independent monitor
module tb_regfile_mp;
  localparam int DW = 32, NR = 16, AW = 4, NRD = 3, NWR = 2;
  localparam int K_RD = 0, K_BUSY = 1, K_VEC = 2, K_FLAGS = 3, K_PCV = 4, K_PCD = 5;
  logic clk = 1'b0;
  logic rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic [NWR-1:0] wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [DW-1:0] pc_in;
  logic pc_wr_valid;
  logic [DW-1:0] pc_wr_data;
  logic busy_set;
  logic [AW-1:0] busy_addr;
  logic [NR-1:0] busy_vec;
  logic flags_we;
  logic [3:0] flags_in;
  logic [3:0] flags;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pc_in(pc_in),
    .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_vec(busy_vec), .flags_we(flags_we),
    .flags_in(flags_in), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int kind;
    int idx;
    logic [31:0] exp;
    string name;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int kind, int idx);
    case (kind)
      K_RD:    return rd_data[idx*DW +: DW];
      K_BUSY:  return 32'(rd_busy[idx]);
      K_VEC:   return 32'(busy_vec);
      K_FLAGS: return 32'(flags);
      K_PCV:   return 32'(pc_wr_valid);
      default: return pc_wr_data;
    endcase
  endfunction

  // monitor: every output sample due by this cycle is compared against its queued expectation
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.kind, e.idx);
      total++;
      if (a === e.exp) passed++;
      else $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
    end
  end

  task automatic expect_out(int kind, int idx, logic [31:0] exp, string name);
    exp_t e;
    e.due = cyc + 1;
    e.kind = kind;
    e.idx = idx;
    e.exp = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic idle();
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    busy_set = 1'b0;
    busy_addr = '0;
    flags_we = 1'b0;
    flags_in = '0;
  endtask

  task automatic rd(int i, int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(int j, int a, logic [31:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    pc_in = 32'h100;
    step();
    rst = 1'b0;
    // preload, with a same-cycle bypass read of R1
    wr(0, 1, 32'hAAAA); wr(1, 2, 32'hBBBB);
    busy_set = 1'b1; busy_addr = 4;
    flags_we = 1'b1; flags_in = 4'hF;
    rd(0, 1);
    expect_out(K_RD, 0, 32'hAAAA, "preload_bypass");
    step();
    // reset overrides same-cycle write, set and flag update
    rst = 1'b1;
    wr(0, 1, 32'h1234);
    busy_set = 1'b1; busy_addr = 5;
    flags_we = 1'b1; flags_in = 4'h3;
    rd(0, 1); rd(1, 2);
    expect_out(K_RD, 0, 0, "rst_rd0");
    expect_out(K_RD, 1, 0, "rst_rd1");
    expect_out(K_VEC, 0, 0, "rst_busy_vec");
    expect_out(K_FLAGS, 0, 0, "rst_flags");
    expect_out(K_PCV, 0, 0, "rst_pc_valid");
    step();
    rst = 1'b0;
    rd(0, 1); rd(1, 2); rd(2, 4);
    expect_out(K_RD, 0, 0, "post_rst_r1");
    expect_out(K_RD, 1, 0, "post_rst_r2");
    expect_out(K_BUSY, 2, 0, "post_rst_busy_r4");
    expect_out(K_VEC, 0, 0, "post_rst_vec");
    step();
    // write then read
    wr(0, 3, 32'hDEADBEEF);
    step();
    rd(0, 3);
    expect_out(K_RD, 0, 32'hDEADBEEF, "r3_read");
    step();
    // same-address priority with bypass
    wr(0, 5, 32'h11); wr(1, 5, 32'h22);
    rd(1, 5);
    expect_out(K_RD, 1, 32'h22, "r5_bypass_prio");
    step();
    rd(2, 5);
    expect_out(K_RD, 2, 32'h22, "r5_held");
    step();
    // different addresses both commit
    wr(0, 8, 32'h88); wr(1, 9, 32'h99);
    step();
    rd(0, 8); rd(1, 9);
    expect_out(K_RD, 0, 32'h88, "r8_read");
    expect_out(K_RD, 1, 32'h99, "r9_read");
    step();
    // virtual PC read and redirect pulse
    rd(0, 15);
    wr(0, 15, 32'h400);
    expect_out(K_RD, 0, 32'h108, "pc_read");
    expect_out(K_PCV, 0, 1, "pc_wr_valid_on");
    expect_out(K_PCD, 0, 32'h400, "pc_wr_data");
    step();
    rd(0, 15);
    expect_out(K_RD, 0, 32'h108, "pc_read_after_wr");
    expect_out(K_PCV, 0, 0, "pc_wr_valid_off");
    step();
    wr(0, 15, 32'h111); wr(1, 15, 32'h222);
    expect_out(K_PCV, 0, 1, "pc_prio_valid");
    expect_out(K_PCD, 0, 32'h222, "pc_prio_data");
    step();
    // scoreboard set / set-beats-clear / clear / PC ignored
    busy_set = 1'b1; busy_addr = 7;
    rd(0, 7);
    expect_out(K_VEC, 0, 32'h0080, "busy_set_r7");
    expect_out(K_BUSY, 0, 1, "rd_busy_r7");
    step();
    busy_set = 1'b1; busy_addr = 7;
    wr(0, 7, 32'h77);
    rd(1, 7);
    expect_out(K_VEC, 0, 32'h0080, "busy_set_wins");
    expect_out(K_BUSY, 1, 1, "rd_busy_set_wins");
    step();
    wr(1, 7, 32'h99);
    rd(2, 7);
    expect_out(K_VEC, 0, 0, "busy_clear_r7");
    expect_out(K_BUSY, 2, 0, "rd_busy_cleared");
    expect_out(K_RD, 2, 32'h99, "r7_bypass");
    step();
    busy_set = 1'b1; busy_addr = 15;
    rd(0, 15);
    expect_out(K_VEC, 0, 0, "busy_pc_ignored");
    expect_out(K_BUSY, 0, 0, "rd_busy_pc");
    step();
    // PC offset wrap and flags
    pc_in = 32'hFFFFFFFC;
    rd(1, 15);
    flags_we = 1'b1; flags_in = 4'b1010;
    expect_out(K_RD, 1, 32'h4, "pc_wrap");
    expect_out(K_FLAGS, 0, 32'hA, "flags_write");
    step();
    flags_in = 4'b0101;
    expect_out(K_FLAGS, 0, 32'hA, "flags_hold");
    step();
    repeat (3) step();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      total += q.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
